axil_reg_slave: RTL

AXI4-Lite responder that exposes a bank of 32-bit software-visible registers to a single AXI4-Lite master, such as the BFM master used in the block-design bench. It accepts write-address, write-data and read-address independently, commits strobed writes, and returns OKAY/SLVERR responses. Register contents are also driven out in parallel for use by the surrounding IP logic.

---
 rtl/axil_reg_pkg.sv | 36 +++
 rtl/axil_hold_buf.sv | 38 +++
 rtl/axil_reg_slave.sv | 116 +++++++++++
 3 files changed

// File: rtl/axil_reg_pkg.sv
// Shared constants, payload structs and address-decode helpers for the
// AXI4-Lite register slave.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  // Write-data beat as captured by the W hold buffer.
  typedef struct packed {
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
  } w_beat_t;

  // Read response as held on the R channel.
  typedef struct packed {
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] data;
  } r_beat_t;

  // Word index of a byte address; num_regs is a power of two.
  function automatic int unsigned addr_to_idx(input logic [63:0] addr,
                                              input int unsigned num_regs);
    return 32'(addr[33:2]) & (num_regs - 1);
  endfunction

  // True when no bit above the index field is set. For a power-of-two
  // register count this is the same as addr < num_regs * 4.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned num_regs);
    return addr < (64'(num_regs) << 2);
  endfunction

endpackage

// File: rtl/axil_hold_buf.sv
// Single-entry valid/ready holding register. Ready is registered and equals
// "buffer empty"; it stays low while in reset and rises on the first edge
// after reset is released.
module axil_hold_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] d,
  input  logic         clear,
  output logic         full,
  output logic [W-1:0] q
);

  logic load;
  logic full_next;

  assign load      = valid && ready;
  assign full_next = (full && !clear) || load;

  // Capture on handshake, drop on clear; ready tracks the next empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so full/ready/q update together without ordering races.
      full  <= full_next;
      ready <= !full_next;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit registers. AW and W are
// captured independently and committed together; reads are answered from
// the register array one edge after the AR handshake.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_WIDTH-1:0]      AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_WIDTH-1:0]      WDATA,
  input  logic [STRB_WIDTH-1:0]      WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_WIDTH-1:0]      ARADDR,
  input  logic [2:0]                 ARPROT,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_WIDTH-1:0]      RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*32-1:0]     reg_q
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [ADDR_WIDTH-1:0] aw_q;
  logic                  aw_full;
  w_beat_t               w_q;
  logic                  w_full;
  r_beat_t               r_next;
  r_beat_t               r_q;
  logic                  commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Protection bits carry no meaning for this slave.
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  axil_hold_buf #(.W(ADDR_WIDTH)) u_aw_buf (
    .clk(ACLK), .rst(ARESET), .valid(AWVALID), .ready(AWREADY),
    .d(AWADDR), .clear(commit), .full(aw_full), .q(aw_q)
  );

  axil_hold_buf #(.W($bits(w_beat_t))) u_w_buf (
    .clk(ACLK), .rst(ARESET), .valid(WVALID), .ready(WREADY),
    .d({WSTRB, WDATA}), .clear(commit), .full(w_full), .q(w_q)
  );

  // The AR buffer holds the read response itself: full is RVALID, so
  // ARREADY is low for as long as a response is waiting for RREADY.
  axil_hold_buf #(.W($bits(r_beat_t))) u_ar_buf (
    .clk(ACLK), .rst(ARESET), .valid(ARVALID), .ready(ARREADY),
    .d(r_next), .clear(RVALID && RREADY), .full(RVALID), .q(r_q)
  );

  assign RDATA = r_q.data;
  assign RRESP = r_q.resp;

  // One write outstanding at a time: commit waits for the B channel to drain.
  assign commit = aw_full && w_full && !BVALID;

  assign wr_idx = IDX_W'(addr_to_idx(64'(aw_q), NUM_REGS));
  assign wr_ok  = addr_in_range(64'(aw_q), NUM_REGS);
  assign rd_idx = IDX_W'(addr_to_idx(64'(ARADDR), NUM_REGS));
  assign rd_ok  = addr_in_range(64'(ARADDR), NUM_REGS);

  // Read response from the pre-edge register contents, zero when out of range.
  always_comb begin
    // NOTE: the default assignment first means every path drives r_next,
    // so no latch is inferred.
    r_next = '{resp: RESP_SLVERR, data: '0};
    if (rd_ok) r_next = '{resp: RESP_OKAY, data: regs[rd_idx]};
  end

  // Register array with byte strobes, plus the B response register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      // NOTE: the register array is software-visible state, so it is reset
      // explicitly rather than left as uninitialised storage.
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      BVALID <= 1'b0;
      BRESP  <= RESP_OKAY;
    end else begin
      if (commit) begin
        if (wr_ok) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_q.strb[b]) regs[wr_idx][8*b +: 8] <= w_q.data[8*b +: 8];
          end
        end
        BVALID <= 1'b1;
        BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg_q
    assign reg_q[32*i +: 32] = regs[i];
  end

endmodule
